// File: rtl/p_hit_min_reader.sv
// p_hit_min_reader: drains the p_hit_1 result FIFO and reduces each group of
// NUM_TRI signed Q16.16 hit distances to the closest valid hit of that ray.
// One {hit, idx, t} record per ray is pushed into a downstream FIFO.
module p_hit_min_reader #(
    parameter int                 Q_BITS  = 16,
    parameter int                 NUM_TRI = 4,
    parameter int                 IDX_W   = 16,
    parameter logic signed [31:0] T_EPS   = 32'sd1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [31:0]      in_dout,
    input  logic                    in_empty,
    output logic                    in_rd_en,
    output logic signed [31:0]      out_t,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_hit,
    input  logic                    out_full,
    output logic                    out_wr_en,
    output logic                    busy
);

    // Q_BITS only documents the fixed-point format; comparisons use raw words.
    // An illegal parameter set stops elaboration instead of silently misbehaving.
    generate
        if (NUM_TRI < 1 || NUM_TRI > 65535 || Q_BITS < 0 || Q_BITS > 31 || IDX_W < 1) begin : g_bad_param
            $error("p_hit_min_reader: illegal parameter set");
        end
    endgenerate

    localparam int                 CNT_W    = 16;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(NUM_TRI - 1);
    localparam logic signed [31:0] T_INF    = 32'sh7FFFFFFF;

    typedef enum logic {
        S_ACC,
        S_EMIT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    count;
    logic signed [31:0]  best_t;
    logic [IDX_W-1:0]    best_idx;
    logic                best_hit;

    logic                pop;
    logic                take;
    logic                last;
    logic signed [31:0]  cand_t;
    logic [IDX_W-1:0]    cand_idx;
    logic                cand_hit;

    // Candidate best after folding in the element at the FIFO head.
    // Strict less-than means ties keep the earlier (lower) triangle index.
    always_comb begin
        take     = (in_dout > T_EPS) && (in_dout < best_t);
        cand_t   = take ? in_dout : best_t;
        cand_idx = take ? IDX_W'(count) : best_idx;
        cand_hit = take | best_hit;
        last     = (count == LAST_CNT);
    end

    // Handshakes, busy flag and next-state; nothing is popped or written while reset is held.
    always_comb begin
        next_state = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        pop        = 1'b0;
        busy       = (count != '0) || (state == S_EMIT);
        case (state)
            S_ACC: begin
                in_rd_en = reset && !in_empty;
                pop      = in_rd_en;
                if (pop && last) begin
                    next_state = S_EMIT;
                end
            end
            S_EMIT: begin
                out_wr_en = reset && !out_full;
                if (out_wr_en) begin
                    next_state = S_ACC;
                end
            end
            default: begin
                next_state = S_ACC;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_ACC;
        end else begin
            state <= next_state;
        end
    end

    // Running minimum, element counter and the registered output record.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            best_t   <= T_INF;
            best_idx <= '0;
            best_hit <= 1'b0;
            out_t    <= '0;
            out_idx  <= '0;
            out_hit  <= 1'b0;
        end else begin
            if (pop) begin
                best_t   <= cand_t;
                best_idx <= cand_idx;
                best_hit <= cand_hit;
                if (last) begin
                    out_t   <= cand_t;
                    out_idx <= cand_idx;
                    out_hit <= cand_hit;
                    count   <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (out_wr_en) begin
                best_t   <= T_INF;
                best_idx <= '0;
                best_hit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_p_hit_min_reader.sv
// Self-checking bench for p_hit_min_reader (NUM_TRI=4): directed vector table,
// multi-cycle corner sequences, and a randomized run against a reference model.
module tb_p_hit_min_reader;

    typedef struct packed {
        logic [31:0] t;
        logic [15:0] idx;
        logic        hit;
    } rec_t;

    typedef struct packed {
        logic [3:0][31:0] v;
        rec_t             exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] out_t;
    logic [15:0] out_idx;
    logic        out_hit;
    logic        out_full;
    logic        out_wr_en;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    p_hit_min_reader #(
        .Q_BITS (16),
        .NUM_TRI(4),
        .IDX_W  (16),
        .T_EPS  (32'sd1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .out_t    (out_t),
        .out_idx  (out_idx),
        .out_hit  (out_hit),
        .out_full (out_full),
        .out_wr_en(out_wr_en),
        .busy     (busy)
    );

    // Free-running clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Closest valid hit of a ray: among values strictly above epsilon, the
    // smallest one; the first occurrence wins ties. No valid value means a miss.
    function automatic rec_t ref_ray(input logic [3:0][31:0] v);
        rec_t r;
        r.t   = 32'h7FFFFFFF;
        r.idx = 16'd0;
        r.hit = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if ($signed(v[j]) > 32'sd1 && $signed(v[j]) < $signed(r.t)) begin
                r.t   = v[j];
                r.idx = 16'(j);
                r.hit = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input logic [31:0] d, input logic [31:0] et, input logic [15:0] ei,
                                input logic eh);
        vec_t x;
        x.v[0]    = a;
        x.v[1]    = b;
        x.v[2]    = c;
        x.v[3]    = d;
        x.exp.t   = et;
        x.exp.idx = ei;
        x.exp.hit = eh;
        return x;
    endfunction

    task automatic doReset();
        reset    = 1'b0;
        in_empty = 1'b0;
        in_dout  = 32'h00010000;
        out_full = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rst_in_rd_en", 32'(in_rd_en), 32'd0);
        checkOutput("rst_out_wr_en", 32'(out_wr_en), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_t", out_t, 32'd0);
        checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
        checkOutput("rst_out_hit", 32'(out_hit), 32'd0);
        in_empty = 1'b1;
        reset    = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Feeds one ray with 'gap' empty cycles after each pop and captures the record.
    task automatic applyStimulus(input logic [3:0][31:0] vals, input int gap, output rec_t got,
                                 output int latency, output int extra, output int busy_err,
                                 output bit ok);
        int  i       = 0;
        int  gapcnt  = 0;
        int  pop_cyc = 0;
        bit  popped;
        ok       = 1'b0;
        latency  = -1;
        extra    = 0;
        busy_err = 0;
        got      = '0;
        for (int k = 0; k < 300 && !ok; k++) begin
            out_full = 1'b0;
            if (i < 4 && gapcnt == 0) begin
                in_empty = 1'b0;
                in_dout  = vals[i];
            end else begin
                in_empty = 1'b1;
                in_dout  = 32'hDEAD0000;
            end
            @(negedge clock);
            if (busy !== (i > 0)) busy_err++;
            if (out_wr_en) begin
                got.t   = out_t;
                got.idx = out_idx;
                got.hit = out_hit;
                ok      = 1'b1;
                latency = cyc - pop_cyc;
            end
            popped = in_rd_en;
            if (popped && i == 3) pop_cyc = cyc;
            @(posedge clock);
            #1;
            if (popped) begin
                i++;
                gapcnt = gap;
            end else if (gapcnt > 0) begin
                gapcnt--;
            end
        end
        in_empty = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (out_wr_en) extra++;
            if (busy) busy_err++;
            @(posedge clock);
            #1;
        end
    endtask

    vec_t        tv[7];
    rec_t        got;
    rec_t        exp;
    int          lat;
    int          extra;
    int          berr;
    bit          ok;
    int          viol;
    logic [3:0][31:0] v1;
    logic [3:0][31:0] rv;
    logic [31:0] src[$];
    rec_t        exp_q[$];
    int          writes;
    bit          popped;

    initial begin
        tv[0] = mk(32'h00030000, 32'h00010000, 32'h00020000, 32'h00050000, 32'h00010000, 16'd1, 1'b1);
        tv[1] = mk(32'hFFFF0000, 32'h00000000, 32'h00000001, 32'h80000000, 32'h7FFFFFFF, 16'd0, 1'b0);
        tv[2] = mk(32'h00020000, 32'h00040000, 32'h00020000, 32'h00030000, 32'h00020000, 16'd0, 1'b1);
        tv[3] = mk(32'h00000002, 32'h00000002, 32'h00000005, 32'h00000003, 32'h00000002, 16'd0, 1'b1);
        tv[4] = mk(32'h00000001, 32'h7FFFFFFF, 32'h00000009, 32'h00000009, 32'h00000009, 16'd2, 1'b1);
        tv[5] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 16'd0, 1'b0);
        tv[6] = mk(32'h00000005, 32'h00000004, 32'h00000003, 32'h00000002, 32'h00000002, 16'd3, 1'b1);
        v1    = tv[0].v;

        doReset();

        // Directed vector table, back-to-back elements.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(tv[k].v, 0, got, lat, extra, berr, ok);
            checkOutput($sformatf("vec%0d_written", k), 32'(ok), 32'd1);
            checkOutput($sformatf("vec%0d_t", k), got.t, tv[k].exp.t);
            checkOutput($sformatf("vec%0d_idx", k), 32'(got.idx), 32'(tv[k].exp.idx));
            checkOutput($sformatf("vec%0d_hit", k), 32'(got.hit), 32'(tv[k].exp.hit));
            checkOutput($sformatf("vec%0d_latency", k), 32'(lat), 32'd1);
            checkOutput($sformatf("vec%0d_single_write", k), 32'(extra), 32'd0);
            checkOutput($sformatf("vec%0d_busy", k), 32'(berr), 32'd0);
        end

        // Empty bubbles between every element leave the record unchanged.
        applyStimulus(v1, 3, got, lat, extra, berr, ok);
        checkOutput("bubble_written", 32'(ok), 32'd1);
        checkOutput("bubble_t", got.t, 32'h00010000);
        checkOutput("bubble_idx", 32'(got.idx), 32'd1);
        checkOutput("bubble_hit", 32'(got.hit), 32'd1);
        checkOutput("bubble_busy", 32'(berr), 32'd0);
        checkOutput("bubble_single_write", 32'(extra), 32'd0);

        // Downstream full: record held, upstream back-pressured, then one write.
        viol     = 0;
        out_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_empty = 1'b0;
            in_dout  = v1[k];
            @(negedge clock);
            if (in_rd_en !== 1'b1) viol++;
            @(posedge clock);
            #1;
        end
        checkOutput("full_pops", 32'(viol), 32'd0);
        in_dout = 32'h00090000;
        viol    = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (out_wr_en !== 1'b0 || in_rd_en !== 1'b0) viol++;
            if (out_t !== 32'h00010000 || out_idx !== 16'd1 || out_hit !== 1'b1) viol++;
            @(posedge clock);
            #1;
        end
        checkOutput("full_hold", 32'(viol), 32'd0);
        out_full = 1'b0;
        @(negedge clock);
        checkOutput("full_release_wr", 32'(out_wr_en), 32'd1);
        checkOutput("full_release_t", out_t, 32'h00010000);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("full_next_rd", 32'(in_rd_en), 32'd1);
        checkOutput("full_no_rewrite", 32'(out_wr_en), 32'd0);
        @(posedge clock);
        #1;

        // Reset mid-ray discards the partial ray.
        doReset();
        for (int k = 0; k < 2; k++) begin
            in_empty = 1'b0;
            in_dout  = (k == 0) ? 32'h00010000 : 32'h00020000;
            @(negedge clock);
            @(posedge clock);
            #1;
        end
        in_empty = 1'b1;
        @(negedge clock);
        checkOutput("partial_busy", 32'(busy), 32'd1);
        doReset();
        rv[0] = 32'h00050000;
        rv[1] = 32'h00060000;
        rv[2] = 32'h00040000;
        rv[3] = 32'h00070000;
        applyStimulus(rv, 0, got, lat, extra, berr, ok);
        checkOutput("abort_written", 32'(ok), 32'd1);
        checkOutput("abort_t", got.t, 32'h00040000);
        checkOutput("abort_idx", 32'(got.idx), 32'd2);
        checkOutput("abort_hit", 32'(got.hit), 32'd1);

        // Randomized rays with random bubbles and downstream back-pressure.
        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < 4; j++) begin
                case ($urandom_range(0, 3))
                    0:       rv[j] = 32'($urandom_range(0, 3)) - 32'd1;
                    1:       rv[j] = $urandom;
                    2:       rv[j] = 32'($urandom_range(0, 15));
                    default: rv[j] = 32'h7FFFFFFE + 32'($urandom_range(0, 1));
                endcase
                src.push_back(rv[j]);
            end
            exp_q.push_back(ref_ray(rv));
        end
        writes = 0;
        viol   = 0;
        for (int k = 0; k < 4000 && writes < 40; k++) begin
            in_empty = (src.size() == 0) || ($urandom_range(0, 3) == 0);
            in_dout  = (src.size() != 0) ? src[0] : $urandom;
            out_full = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            if (in_rd_en && in_empty) viol++;
            if (out_wr_en && out_full) viol++;
            if (out_wr_en) begin
                writes++;
                if (exp_q.size() == 0) begin
                    viol++;
                end else begin
                    exp = exp_q.pop_front();
                    checkOutput($sformatf("rand%0d_t", writes), out_t, exp.t);
                    checkOutput($sformatf("rand%0d_idx", writes), 32'(out_idx), 32'(exp.idx));
                    checkOutput($sformatf("rand%0d_hit", writes), 32'(out_hit), 32'(exp.hit));
                end
            end
            popped = in_rd_en;
            @(posedge clock);
            #1;
            if (popped && src.size() != 0) void'(src.pop_front());
        end
        checkOutput("rand_writes", 32'(writes), 32'd40);
        checkOutput("rand_protocol", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
